// File: rtl/fp_mult_sched.sv
// fp_mult_sched: two requesters share one single-precision multiplier.
// A round-robin arbiter grants one request at a time. The operands are
// registered, multiplied in the next cycle, and the result is held on the
// output port until the consumer takes it.
// Optional exception counter: define FP_MULT_EXC_CNT_EN to add cnt_clr/exc_cnt.
//
// fp_mult: combinational IEEE-754 binary32 multiplier.
// status bits: [0] zero, [1] infinity, [2] nan, [3] tiny, [4] huge, [5] inexact.
// rnd: 000 nearest-even, 001 toward zero, 010 toward +inf, 011 toward -inf,
//      100 nearest ties-away, 101 away from zero, others as nearest-even.

module fp_mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic [31:0] z,
    output logic [7:0]  status
);

    logic               signZ;
    logic [7:0]         expA, expB, effA, effB;
    logic [22:0]        fracA, fracB;
    logic               aZero, bZero, aInf, bInf, aNan, bNan;
    logic [23:0]        sigA, sigB;
    logic [47:0]        prod, normProd, alignedProd, lostMask;
    logic [5:0]         lead, shamt;
    logic signed [10:0] biasedExp, rawShift;
    logic [7:0]         expPre;
    logic [22:0]        fracPre;
    logic               guardBit, stickyBit, roundInc, roundUpOnOvf;
    logic [30:0]        rounded;
    logic               tiny, overflow, inexact;

    // Unpack operands, multiply significands, normalise, round and pack.
    always_comb begin
        signZ     = a[31] ^ b[31];
        expA      = a[30:23];
        expB      = b[30:23];
        fracA     = a[22:0];
        fracB     = b[22:0];
        aZero     = (expA == 8'd0) && (fracA == 23'd0);
        bZero     = (expB == 8'd0) && (fracB == 23'd0);
        aInf      = (expA == 8'hFF) && (fracA == 23'd0);
        bInf      = (expB == 8'hFF) && (fracB == 23'd0);
        aNan      = (expA == 8'hFF) && (fracA != 23'd0);
        bNan      = (expB == 8'hFF) && (fracB != 23'd0);
        effA      = (expA == 8'd0) ? 8'd1 : expA;
        effB      = (expB == 8'd0) ? 8'd1 : expB;
        sigA      = {expA != 8'd0, fracA};
        sigB      = {expB != 8'd0, fracB};
        prod      = {24'd0, sigA} * {24'd0, sigB};

        lead = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) begin
                lead = i[5:0];
            end
        end

        // Exponent of the product once its leading one sits at bit 47.
        biasedExp = $signed({5'd0, lead}) + $signed({3'd0, effA})
                  + $signed({3'd0, effB}) - 11'sd173;
        normProd  = prod << (6'd47 - lead);

        rawShift    = 11'sd1 - biasedExp;
        shamt       = (rawShift > 11'sd48) ? 6'd48 : rawShift[5:0];
        lostMask    = ~({48{1'b1}} << shamt);
        alignedProd = normProd >> shamt;

        if (biasedExp >= 11'sd1) begin
            tiny      = 1'b0;
            expPre    = biasedExp[7:0];
            fracPre   = normProd[46:24];
            guardBit  = normProd[23];
            stickyBit = |normProd[22:0];
        end else begin
            tiny      = 1'b1;
            expPre    = {7'd0, alignedProd[47]};
            fracPre   = alignedProd[46:24];
            guardBit  = alignedProd[23];
            stickyBit = (|alignedProd[22:0]) | (|(normProd & lostMask));
        end

        case (rnd)
            3'b001:  roundInc = 1'b0;
            3'b010:  roundInc = !signZ && (guardBit || stickyBit);
            3'b011:  roundInc = signZ && (guardBit || stickyBit);
            3'b100:  roundInc = guardBit;
            3'b101:  roundInc = guardBit || stickyBit;
            default: roundInc = guardBit && (stickyBit || fracPre[0]);
        endcase

        case (rnd)
            3'b001:  roundUpOnOvf = 1'b0;
            3'b010:  roundUpOnOvf = !signZ;
            3'b011:  roundUpOnOvf = signZ;
            default: roundUpOnOvf = 1'b1;
        endcase

        // A carry out of the fraction bumps the exponent field naturally.
        rounded  = {expPre, fracPre} + {30'd0, roundInc};
        overflow = (biasedExp > 11'sd254) || (rounded[30:23] == 8'hFF);
        inexact  = guardBit || stickyBit;

        z      = {signZ, rounded};
        status = {2'b00, inexact, 1'b0, tiny, 1'b0, 1'b0, rounded == 31'd0};

        if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
            z      = 32'h7FC00000;
            status = 8'h04;
        end else if (aInf || bInf) begin
            z      = {signZ, 8'hFF, 23'd0};
            status = 8'h02;
        end else if (aZero || bZero) begin
            z      = {signZ, 31'd0};
            status = 8'h01;
        end else if (overflow) begin
            z      = roundUpOnOvf ? {signZ, 8'hFF, 23'd0} : {signZ, 8'hFE, 23'h7FFFFF};
            status = {2'b00, 1'b1, 1'b1, 2'b00, roundUpOnOvf, 1'b0};
        end
    end

endmodule

module fp_mult_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_rnd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic [7:0]  out_status,
    output logic        out_id
`ifdef FP_MULT_EXC_CNT_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] exc_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      state_q, state_d;
    logic        lastServed_q;
    logic [31:0] opA_q, opB_q;
    logic [2:0]  opRnd_q;
    logic        opId_q;
    logic [31:0] outZ_q;
    logic [7:0]  outStatus_q;
    logic        outId_q;
    logic        grant0, grant1, accept0, accept1;
    logic [31:0] multZ;
    logic [7:0]  multStatus;

    fp_mult uMult (
        .a      (opA_q),
        .b      (opB_q),
        .rnd    (opRnd_q),
        .z      (multZ),
        .status (multStatus)
    );

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || lastServed_q);
        grant1     = req1_valid && (!req0_valid || !lastServed_q);
        req0_ready = (state_q == IDLE) && grant0 && !rst;
        req1_ready = (state_q == IDLE) && grant1 && !rst;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
    end

    // Next-state logic for the accept / execute / deliver sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept0 || accept1) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand capture, arbitration pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lastServed_q <= 1'b1;
            opA_q        <= 32'd0;
            opB_q        <= 32'd0;
            opRnd_q      <= 3'd0;
            opId_q       <= 1'b0;
            outZ_q       <= 32'd0;
            outStatus_q  <= 8'd0;
            outId_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept0) begin
                opA_q        <= req0_a;
                opB_q        <= req0_b;
                opRnd_q      <= req0_rnd;
                opId_q       <= 1'b0;
                lastServed_q <= 1'b0;
            end else if (accept1) begin
                opA_q        <= req1_a;
                opB_q        <= req1_b;
                opRnd_q      <= req1_rnd;
                opId_q       <= 1'b1;
                lastServed_q <= 1'b1;
            end
            if (state_q == EXEC) begin
                outZ_q      <= multZ;
                outStatus_q <= multStatus;
                outId_q     <= opId_q;
            end
        end
    end

    assign out_valid  = (state_q == DONE);
    assign out_z      = outZ_q;
    assign out_status = outStatus_q;
    assign out_id     = outId_q;

`ifdef FP_MULT_EXC_CNT_EN
    logic [15:0] excCnt_q;

    // Count delivered results flagged nan, tiny or huge; clear wins over count.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            excCnt_q <= 16'd0;
        end else if (out_valid && out_ready && (|out_status[4:2])
                     && (excCnt_q != 16'hFFFF)) begin
            excCnt_q <= excCnt_q + 16'd1;
        end
    end

    assign exc_cnt = excCnt_q;
`endif

endmodule

// File: tb/tb_fp_mult_sched.sv
// Testbench for fp_mult_sched: a transaction-level model predicts grants,
// result timing and values; directed scenarios add literal expectations.
// Define FP_MULT_EXC_CNT_EN to also exercise the exception counter.

module tb_fp_mult_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_rnd, req1_rnd;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_z;
    logic [7:0]  out_status;
`ifdef FP_MULT_EXC_CNT_EN
    logic        cnt_clr;
    logic [15:0] exc_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    fp_mult_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_rnd   (req0_rnd),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_rnd   (req1_rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_status (out_status),
        .out_id     (out_id)
`ifdef FP_MULT_EXC_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .exc_cnt    (exc_cnt)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Hand-computed binary32 products for every operand set the bench issues.
    function automatic void refMult(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] r, output logic [31:0] z,
                                    output logic [7:0] s, output bit known);
        known = 1'b1;
        case ({a, b, r})
            {32'h3FC00000, 32'h40000000, 3'd0}: begin z = 32'h40400000; s = 8'h00; end
            {32'hC0000000, 32'h40400000, 3'd0}: begin z = 32'hC0C00000; s = 8'h00; end
            {32'h7F000000, 32'h7F000000, 3'd0}: begin z = 32'h7F800000; s = 8'h32; end
            {32'h7F000000, 32'h7F000000, 3'd1}: begin z = 32'h7F7FFFFF; s = 8'h30; end
            {32'h00000000, 32'h40000000, 3'd0}: begin z = 32'h00000000; s = 8'h01; end
            {32'h7FC00000, 32'h3F800000, 3'd0}: begin z = 32'h7FC00000; s = 8'h04; end
            {32'h7F800000, 32'h00000000, 3'd0}: begin z = 32'h7FC00000; s = 8'h04; end
            {32'h7F800000, 32'hBF800000, 3'd0}: begin z = 32'hFF800000; s = 8'h02; end
            {32'h3F800001, 32'h3F800001, 3'd0}: begin z = 32'h3F800002; s = 8'h20; end
            {32'h3F800001, 32'h3F800001, 3'd1}: begin z = 32'h3F800002; s = 8'h20; end
            {32'h3F800001, 32'h3F800001, 3'd2}: begin z = 32'h3F800003; s = 8'h20; end
            {32'h3F800001, 32'h3F800001, 3'd3}: begin z = 32'h3F800002; s = 8'h20; end
            {32'hBF800001, 32'h3F800001, 3'd3}: begin z = 32'hBF800003; s = 8'h20; end
            {32'h00800000, 32'h3F000000, 3'd0}: begin z = 32'h00400000; s = 8'h08; end
            default: begin z = 32'h0; s = 8'h0; known = 1'b0; end
        endcase
    endfunction

    // Transaction model: one outstanding job, result visible two cycles
    // after acceptance and held until taken, round-robin on ties.
    bit          pending = 1'b0;
    bit          lastSrv = 1'b1;
    int          cycle   = 0;
    int          pendAt  = 0;
    logic [31:0] pendZ   = '0;
    logic [7:0]  pendS   = '0;
    logic        pendId  = 1'b0;
    int          excModel = 0;
    bit          expR0, expR1, expV, deliver, known;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
            checkOutput("rst_ready1", {31'd0, req1_ready}, 32'd0);
            pending  = 1'b0;
            lastSrv  = 1'b1;
            excModel = 0;
        end else begin
            expV  = pending && (cycle >= pendAt);
            expR0 = !pending && req0_valid && (!req1_valid || lastSrv);
            expR1 = !pending && req1_valid && (!req0_valid || !lastSrv);
            checkOutput("model_ready0", {31'd0, req0_ready}, {31'd0, expR0});
            checkOutput("model_ready1", {31'd0, req1_ready}, {31'd0, expR1});
            checkOutput("model_out_valid", {31'd0, out_valid}, {31'd0, expV});
            if (expV) begin
                checkOutput("model_out_z", out_z, pendZ);
                checkOutput("model_out_status", {24'd0, out_status}, {24'd0, pendS});
                checkOutput("model_out_id", {31'd0, out_id}, {31'd0, pendId});
            end
            deliver = expV && out_ready;
`ifdef FP_MULT_EXC_CNT_EN
            checkOutput("model_exc_cnt", {16'd0, exc_cnt}, excModel);
            if (cnt_clr)
                excModel = 0;
            else if (deliver && (pendS & 8'h1C) != 8'h00 && excModel < 65535)
                excModel = excModel + 1;
`endif
            if (deliver) pending = 1'b0;
            if (expR0 || expR1) begin
                if (expR0) refMult(req0_a, req0_b, req0_rnd, pendZ, pendS, known);
                else       refMult(req1_a, req1_b, req1_rnd, pendZ, pendS, known);
                if (!known) checkOutput("model_unknown_vector", 32'd0, 32'd1);
                pendId  = expR1;
                lastSrv = expR1;
                pending = 1'b1;
                pendAt  = cycle + 2;
            end
        end
        cycle++;
    end

    task automatic applyStimulus(input int id, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] rnd);
        bit got = 1'b0;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_rnd = rnd; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_rnd = rnd; req1_valid = 1'b1;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic waitValid();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) checkOutput("out_valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  r;
    } vec_t;

    vec_t vecs[12];
    int   ids[4];
    int   nIds;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'd0};
        vecs[1]  = '{32'hC0000000, 32'h40400000, 3'd0};
        vecs[2]  = '{32'h7F000000, 32'h7F000000, 3'd1};
        vecs[3]  = '{32'h7FC00000, 32'h3F800000, 3'd0};
        vecs[4]  = '{32'h7F800000, 32'h00000000, 3'd0};
        vecs[5]  = '{32'h7F800000, 32'hBF800000, 3'd0};
        vecs[6]  = '{32'h3F800001, 32'h3F800001, 3'd0};
        vecs[7]  = '{32'h3F800001, 32'h3F800001, 3'd1};
        vecs[8]  = '{32'h3F800001, 32'h3F800001, 3'd2};
        vecs[9]  = '{32'h3F800001, 32'h3F800001, 3'd3};
        vecs[10] = '{32'hBF800001, 32'h3F800001, 3'd3};
        vecs[11] = '{32'h00800000, 32'h3F000000, 3'd0};

        rst = 1'b1; out_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_rnd = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_rnd = '0;
`ifdef FP_MULT_EXC_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_z", out_z, 32'd0);
        checkOutput("reset_out_status", {24'd0, out_status}, 32'd0);
        checkOutput("reset_out_id", {31'd0, out_id}, 32'd0);
`ifdef FP_MULT_EXC_CNT_EN
        checkOutput("reset_exc_cnt", {16'd0, exc_cnt}, 32'd0);
`endif
        @(posedge clk); #1;

        // Single request with fixed two-cycle latency.
        applyStimulus(0, 32'h3FC00000, 32'h40000000, 3'd0);
        @(negedge clk);
        checkOutput("single_T1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("single_T2_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_T2_out_z", out_z, 32'h40400000);
        checkOutput("single_T2_out_id", {31'd0, out_id}, 32'd0);
        @(posedge clk); #1;

        // Directed operand sweep, alternating requesters.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i % 2, vecs[i].a, vecs[i].b, vecs[i].r);
            waitValid();
            @(posedge clk); #1;
        end

        // Contention from reset: results must alternate starting with 0.
        rst = 1'b1;
        req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rnd = 3'd0; req0_valid = 1'b1;
        req1_a = 32'hC0000000; req1_b = 32'h40400000; req1_rnd = 3'd0; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nIds = 0;
        for (int i = 0; i < 40 && nIds < 4; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ids[nIds] = int'(out_id);
                nIds++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        checkOutput("contention_count", nIds, 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("contention_order", ids[i], i % 2);
        repeat (2) @(posedge clk); #1;

`ifdef FP_MULT_EXC_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
`endif

        // Backpressure: result held five cycles, nothing accepted meanwhile.
        out_ready = 1'b0;
        applyStimulus(0, 32'h7F000000, 32'h7F000000, 3'd0);
        req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rnd = 3'd0; req0_valid = 1'b1;
        req1_a = 32'hC0000000; req1_b = 32'h40400000; req1_rnd = 3'd0; req1_valid = 1'b1;
        waitValid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_out_z", out_z, 32'h7F800000);
            checkOutput("bp_ready0", {31'd0, req0_ready}, 32'd0);
            checkOutput("bp_ready1", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        checkOutput("bp_release_ready0", {31'd0, req0_ready}, 32'd0);
`ifdef FP_MULT_EXC_CNT_EN
        checkOutput("cnt_after_huge", {16'd0, exc_cnt}, 32'd1);
`endif
        @(posedge clk); #1 req1_valid = 1'b0;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                got = req0_ready;
            end
            if (!got) checkOutput("bp_req0_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        repeat (6) @(posedge clk); #1;

`ifdef FP_MULT_EXC_CNT_EN
        // Clear coinciding with a second huge delivery wins.
        applyStimulus(0, 32'h7F000000, 32'h7F000000, 3'd0);
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk);
        checkOutput("cnt_clr_priority", {16'd0, exc_cnt}, 32'd0);
        @(posedge clk); #1;
`endif

        // Zero operand.
        applyStimulus(1, 32'h00000000, 32'h40000000, 3'd0);
        waitValid();
        checkOutput("zero_out_z", out_z, 32'h00000000);
        checkOutput("zero_status0", {31'd0, out_status[0]}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef FP_MULT_EXC_CNT_EN
        checkOutput("zero_cnt_unchanged", {16'd0, exc_cnt}, 32'd0);
`endif
        @(posedge clk); #1;

        // Reset while executing: the in-flight result must never appear.
        applyStimulus(0, 32'h3FC00000, 32'h40000000, 3'd0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rst_exec_no_valid", {31'd0, out_valid}, 32'd0);
        end
        checkOutput("rst_exec_out_z", out_z, 32'd0);
        @(posedge clk); #1;
        req0_a = 32'h3FC00000; req0_b = 32'h40000000; req0_rnd = 3'd0; req0_valid = 1'b1;
        req1_a = 32'hC0000000; req1_b = 32'h40400000; req1_rnd = 3'd0; req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_tie_ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("rst_tie_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fp_mult_sched.md
FP_MULT_SCHED -- requirements
Module: fp_mult_sched

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have ports: req0_valid input 1, req0_ready output 1, req0_a input 32, req0_b input 32, req0_rnd input 3; requester 0 operands and rounding mode.
REQ-003 SHALL have ports: req1_valid input 1, req1_ready output 1, req1_a input 32, req1_b input 32, req1_rnd input 3; same meanings for requester 1.
REQ-004 SHALL have ports: out_valid output 1, out_ready input 1, out_z output 32, out_status output 8, out_id output 1 (0/1 = originating requester).
REQ-005 SHALL have ports, only with FP_MULT_EXC_CNT_EN: cnt_clr input 1; exc_cnt output 16.
REQ-006 SHALL instantiate exactly one fp_mult (a, b, rnd, z, status), shared by both requesters.

Function
REQ-007 SHALL implement FSM states IDLE, EXEC, DONE; encoding free.
REQ-008 SHALL, in IDLE: assert reqN_ready for the granted requester only; the handshake is reqN_valid && reqN_ready in the same cycle.
REQ-009 SHALL arbitrate round-robin: with both valid, grant the requester not served last; with one valid, grant it; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-010 SHALL, on handshake, register a, b, rnd and the id into operand registers and move IDLE->EXEC.
REQ-011 SHALL, in EXEC, drive fp_mult from the operand registers; capture z and status into output registers; move EXEC->DONE. reqN_ready is 0.
REQ-012 SHALL, in DONE, assert out_valid with out_z/out_status/out_id stable until out_valid && out_ready; then return to IDLE. reqN_ready is 0.
REQ-013 SHALL give a fixed latency: request accepted in cycle T -> out_valid first high in cycle T+2.
REQ-014 SHALL hold out_valid and its data indefinitely while out_ready is 0 (backpressure); no request is accepted meanwhile.
REQ-015 SHALL ignore out_ready when out_valid is 0.
REQ-016 SHALL update the last-served pointer only on a request handshake.
REQ-017 SHALL allow reqN_valid to drop without a handshake; no state change results.
REQ-018 SHALL achieve a throughput of at most one result per 3 cycles when out_ready is held high.

Reset
REQ-019 SHALL, on rst=1 at a clock edge: FSM->IDLE, out_valid=0, out_z=0, out_status=0, out_id=0, last-served pointer=1, operand registers=0.
REQ-020 SHALL, when reset is asserted mid-operation (EXEC or DONE), discard the in-flight result and produce no out_valid pulse for it.
REQ-021 SHALL drive req0_ready and req1_ready to 0 in the cycle rst is high.

Configuration
REQ-022 SHALL use macro FP_MULT_EXC_CNT_EN. When it is defined, exc_cnt counts delivered results (out handshake) whose out_status[2] (nan) or [3] (tiny) or [4] (huge) is set.
REQ-023 SHALL make exc_cnt saturate at 16'hFFFF; rst or cnt_clr clears it to 0; cnt_clr takes priority over a same-cycle increment.
REQ-024 SHALL, when FP_MULT_EXC_CNT_EN is not defined, omit cnt_clr, exc_cnt and the counter logic, leaving all other behaviour identical.

Verification
REQ-025 SHALL cover single request: req0 a=32'h3FC00000, b=32'h40000000, rnd=000, accepted at T -> out_valid at T+2 with out_z=32'h40400000, out_id=0.
REQ-026 SHALL cover contention: both valid from reset, out_ready=1 -> results in order id 0, 1, 0, 1; each ready only in IDLE.
REQ-027 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_z stable for 5 cycles; req0_ready=0 and req1_ready=0 throughout; release -> IDLE the next cycle.
REQ-028 SHALL cover reset mid-EXEC: rst=1 for 1 cycle during EXEC -> out_valid never asserts for that operation; next tie goes to requester 0.
REQ-029 SHALL cover counter, with FP_MULT_EXC_CNT_EN: a=b=32'h7F000000 delivered -> exc_cnt=1 (huge); cnt_clr asserted together with a second such delivery -> exc_cnt=0.
REQ-030 SHALL cover zero operand: a=32'h00000000, b=32'h40000000 -> out_z=32'h00000000, out_status[0]=1, exc_cnt unchanged.
